sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the requester and SRAM address.
REQ-002 SHALL have parameter DATA_W, default 32, width of the read and write data.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports r0_r_en, r0_w_en  input  1 each  read and write request from requester 0 (data cache controller).
REQ-006 SHALL have ports r0_address  input  ADDR_W, r0_wdata  input  DATA_W  requester 0 address and write data.
REQ-007 SHALL have ports r0_rdata  output  DATA_W, r0_ready  output  1  requester 0 read data and completion pulse.
REQ-008 SHALL have ports r1_r_en, r1_w_en, r1_address, r1_wdata, r1_rdata and r1_ready, with the same directions, widths and meanings, for requester 1.
REQ-009 SHALL have ports sram_r_en, sram_w_en  output  1 each, sram_address  output  ADDR_W, sram_wdata  output  DATA_W  requests to SRAM_Controller.
REQ-010 SHALL have ports sram_rdata  input  DATA_W, sram_ready  input  1  response from SRAM_Controller.
REQ-011 SHALL have ports busy  output  1 (high when not IDLE) and grant  output  1 (index of the current or last owner).

Function
REQ-012 SHALL implement three states: IDLE, BUSY and RESP.
REQ-013 In IDLE, a requester SHALL be pending when its r_en or w_en is 1; with no pending requester, the state SHALL remain IDLE.
REQ-014 In IDLE with one or more requesters pending, the arbiter SHALL select a winner, latch the winner's address, wdata, r_en, w_en and index, and enter BUSY at the next edge.
REQ-015 If r_en and w_en are both 1, the latched operation SHALL be a write, and the read SHALL be discarded.
REQ-016 In BUSY, sram_address and sram_wdata SHALL come only from the latched registers, not from the live requester inputs.
REQ-017 In BUSY, sram_r_en or sram_w_en SHALL come only from the latched operation, with exactly one of them asserted.
REQ-018 In BUSY, when sram_ready=1 the arbiter SHALL capture sram_rdata into the winner's rdata register (reads only) and enter RESP.
REQ-019 In BUSY with sram_ready=0, the arbiter SHALL hold all outputs stable, for an unbounded wait.
REQ-020 In RESP, the owner's rN_ready SHALL be 1 for exactly one cycle, sram enables SHALL be 0, and the next state SHALL be IDLE.
REQ-021 The other requester's ready SHALL remain 0 in every state except its own RESP.
REQ-022 A requester SHALL hold its request stable until it sees its ready pulse, and SHALL deassert it at the edge ending RESP; the arbiter relies on this and does not re-serve the request.
REQ-023 rN_rdata SHALL hold the value of that requester's last completed read, and SHALL be unchanged by writes and by the other requester's transactions.
REQ-024 Minimum latency SHALL be 3 cycles from a request sampled in IDLE to rN_ready (IDLE, BUSY with sram_ready=1, RESP).
REQ-025 Request changes during BUSY or RESP SHALL have no effect until the next IDLE.
REQ-026 sram_ready arriving in IDLE or RESP SHALL be ignored.

Reset
REQ-027 While rst=1, the state SHALL be IDLE and all outputs SHALL be 0.
REQ-028 While rst=1, all latched registers and both rdata registers SHALL be 0.
REQ-029 While rst=1, the round-robin last-owner register SHALL be 1 and grant SHALL be 0.
REQ-030 Reset asserted in BUSY or RESP SHALL abort the transaction immediately, with sram enables dropping asynchronously and no ready pulse.

Configuration
REQ-031 With macro SRAM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the winner SHALL be the requester that did not own the previous transaction, so requester 0 wins first after reset.
REQ-032 With SRAM_ARB_ROUND_ROBIN_EN defined, the last-owner register SHALL update on entry to BUSY, and a single pending requester SHALL always win.
REQ-033 Without SRAM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests (fixed priority), and the last-owner register SHALL be absent.

Verification
REQ-034 r0 read addr 0x40, sram_ready after 4 BUSY cycles with sram_rdata=0xDEADBEEF -> sram_r_en high 4 cycles, r0_ready pulse 1 cycle, r0_rdata=0xDEADBEEF, r1_ready=0.
REQ-035 r1 write addr 0x10, wdata 0x12345678, sram_ready in 1st BUSY cycle -> sram_w_en=1, sram_wdata=0x12345678, r1_ready 3 cycles after request, r1_rdata unchanged.
REQ-036 r0 and r1 requesting continuously in the round-robin build -> grant order 0,1,0,1; in the fixed-priority build -> r0 served until it drops its request.
REQ-037 Change r0_address from 0x40 to 0x80 during BUSY -> sram_address stays 0x40.
REQ-038 Assert rst in the 2nd BUSY cycle -> sram_r_en=0 asynchronously, no ready pulse, IDLE after release.
REQ-039 r0_r_en=1 and r0_w_en=1 together -> SRAM write only, r0_rdata unchanged.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the SRAM controller.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_r_en, r0_w_en, r0_ready;
  logic [ADDR_W-1:0] r0_address;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_r_en, r1_w_en, r1_ready;
  logic [ADDR_W-1:0] r1_address;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic              sram_r_en, sram_w_en, sram_ready;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic              busy, grant;

  modport slave (
    input  r0_r_en, r0_w_en, r0_address, r0_wdata,
    input  r1_r_en, r1_w_en, r1_address, r1_wdata,
    input  sram_rdata, sram_ready,
    output r0_rdata, r0_ready, r1_rdata, r1_ready,
    output sram_r_en, sram_w_en, sram_address, sram_wdata,
    output busy, grant
  );

  modport master (
    output r0_r_en, r0_w_en, r0_address, r0_wdata,
    output r1_r_en, r1_w_en, r1_address, r1_wdata,
    output sram_rdata, sram_ready,
    input  r0_rdata, r0_ready, r1_rdata, r1_ready,
    input  sram_r_en, sram_w_en, sram_address, sram_wdata,
    input  busy, grant
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM controller (IDLE/BUSY/RESP).
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to requester 0.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              pend0, pend1, win;

  assign pend0 = bus.r0_r_en | bus.r0_w_en;
  assign pend1 = bus.r1_r_en | bus.r1_w_en;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On contention the requester that did not own the previous transaction wins.
  assign win = (pend0 & pend1) ? ~last_q : pend1;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (pend0 | pend1)) last_d = win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  assign win = ~pend0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    owner_d  = owner_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (pend0 | pend1) begin
        state_d = BUSY;
        owner_d = win;
        // A write takes precedence when both enables are set; the read is dropped.
        if (win) begin
          addr_d  = bus.r1_address;
          wdata_d = bus.r1_wdata;
          wr_d    = bus.r1_w_en;
        end else begin
          addr_d  = bus.r0_address;
          wdata_d = bus.r0_wdata;
          wr_d    = bus.r0_w_en;
        end
      end
      BUSY: if (bus.sram_ready) begin
        state_d = RESP;
        if (!wr_q) begin
          if (owner_q) rdata1_d = bus.sram_rdata;
          else         rdata0_d = bus.sram_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      owner_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      owner_q  <= owner_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Enables decode straight from the state register so reset drops them asynchronously.
  assign bus.sram_r_en    = (state_q == BUSY) & ~wr_q;
  assign bus.sram_w_en    = (state_q == BUSY) &  wr_q;
  assign bus.sram_address = addr_q;
  assign bus.sram_wdata   = wdata_q;
  assign bus.r0_ready     = (state_q == RESP) & ~owner_q;
  assign bus.r1_ready     = (state_q == RESP) &  owner_q;
  assign bus.r0_rdata     = rdata0_q;
  assign bus.r1_rdata     = rdata1_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.grant        = owner_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; expectations follow SRAM_ARB_ROUND_ROBIN_EN if defined.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   nr;
  logic exp_g [4];

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.r0_r_en = 1'b0; bus.r0_w_en = 1'b0; bus.r0_address = '0; bus.r0_wdata = '0;
    bus.r1_r_en = 1'b0; bus.r1_w_en = 1'b0; bus.r1_address = '0; bus.r1_wdata = '0;
    bus.sram_ready = 1'b0; bus.sram_rdata = '0;
    step();
    step();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_grant", bus.grant, 1'b0);
    chk1("rst_sram_r_en", bus.sram_r_en, 1'b0);
    chk1("rst_sram_w_en", bus.sram_w_en, 1'b0);
    chk1("rst_r0_ready", bus.r0_ready, 1'b0);
    chk32("rst_r0_rdata", bus.r0_rdata, 32'h0);
    chk32("rst_sram_addr", bus.sram_address, 32'h0);
    rst = 1'b0;
    step();

    // r0 read of 0x40, four BUSY cycles, address change ignored mid-transaction
    bus.r0_r_en = 1'b1; bus.r0_address = 32'h40;
    chk1("t1_idle_busy", bus.busy, 1'b0);
    step();
    chk1("t1_busy", bus.busy, 1'b1);
    chk1("t1_grant", bus.grant, 1'b0);
    nr = 0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) bus.r0_address = 32'h80;
      if (bus.sram_r_en) nr++;
      chk32("t1_sram_addr", bus.sram_address, 32'h40);
      chk1("t1_r0_ready_early", bus.r0_ready, 1'b0);
      if (i == 4) begin bus.sram_ready = 1'b1; bus.sram_rdata = 32'hDEADBEEF; end
      step();
    end
    chk32("t1_r_en_cycles", 32'(nr), 32'd4);
    chk1("t1_r0_ready", bus.r0_ready, 1'b1);
    chk1("t1_r1_ready", bus.r1_ready, 1'b0);
    chk1("t1_resp_r_en", bus.sram_r_en, 1'b0);
    chk32("t1_r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
    bus.r0_r_en = 1'b0; bus.r0_address = '0; bus.sram_ready = 1'b0;
    step();
    chk1("t1_ready_pulse_end", bus.r0_ready, 1'b0);
    chk1("t1_back_idle", bus.busy, 1'b0);

    // sram_ready in IDLE with no request is ignored
    bus.sram_ready = 1'b1;
    step();
    chk1("idle_ready_ignored", bus.busy, 1'b0);
    bus.sram_ready = 1'b0;

    // r1 write 0x10, completion in first BUSY cycle
    bus.r1_w_en = 1'b1; bus.r1_address = 32'h10; bus.r1_wdata = 32'h12345678;
    step();
    chk1("t2_w_en", bus.sram_w_en, 1'b1);
    chk1("t2_r_en", bus.sram_r_en, 1'b0);
    chk32("t2_wdata", bus.sram_wdata, 32'h12345678);
    chk32("t2_addr", bus.sram_address, 32'h10);
    chk1("t2_grant", bus.grant, 1'b1);
    bus.sram_ready = 1'b1; bus.sram_rdata = 32'hAAAA5555;
    step();
    chk1("t2_r1_ready", bus.r1_ready, 1'b1);
    chk1("t2_r0_ready", bus.r0_ready, 1'b0);
    chk32("t2_r1_rdata", bus.r1_rdata, 32'h0);
    chk32("t2_r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
    bus.r1_w_en = 1'b0; bus.sram_ready = 1'b0;
    step();
    chk1("t2_r1_ready_end", bus.r1_ready, 1'b0);

    // r0 with both enables set: write only, rdata untouched
    bus.r0_r_en = 1'b1; bus.r0_w_en = 1'b1; bus.r0_address = 32'h20; bus.r0_wdata = 32'h55;
    step();
    chk1("t3_w_en", bus.sram_w_en, 1'b1);
    chk1("t3_r_en", bus.sram_r_en, 1'b0);
    chk32("t3_wdata", bus.sram_wdata, 32'h55);
    bus.sram_ready = 1'b1; bus.sram_rdata = 32'h11111111;
    step();
    chk1("t3_r0_ready", bus.r0_ready, 1'b1);
    chk32("t3_r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
    bus.r0_r_en = 1'b0; bus.r0_w_en = 1'b0; bus.sram_ready = 1'b0;
    step();

    // reset asserted in the second BUSY cycle of a read
    bus.r0_r_en = 1'b1; bus.r0_address = 32'h40;
    step();
    step();
    chk1("t4_pre_r_en", bus.sram_r_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("t4_async_r_en", bus.sram_r_en, 1'b0);
    chk1("t4_async_busy", bus.busy, 1'b0);
    chk1("t4_r0_ready", bus.r0_ready, 1'b0);
    chk32("t4_r0_rdata", bus.r0_rdata, 32'h0);
    bus.r0_r_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk1("t4_idle", bus.busy, 1'b0);
    chk1("t4_no_ready", bus.r0_ready, 1'b0);
    step();
    chk1("t4_no_ready2", bus.r0_ready, 1'b0);

    // both requesters requesting continuously
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    bus.r0_r_en = 1'b1; bus.r1_r_en = 1'b1; bus.sram_ready = 1'b1; bus.sram_rdata = 32'h0BADF00D;
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("t5_busy", bus.busy, 1'b1);
      chk1("t5_grant", bus.grant, exp_g[k]);
      step();
      chk1("t5_r0_ready", bus.r0_ready, ~exp_g[k]);
      chk1("t5_r1_ready", bus.r1_ready, exp_g[k]);
`ifndef SRAM_ARB_ROUND_ROBIN_EN
      if (k == 2) bus.r0_r_en = 1'b0;
`endif
      step();
    end
    bus.r0_r_en = 1'b0; bus.r1_r_en = 1'b0; bus.sram_ready = 1'b0;
    step();
    chk1("t5_idle", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
